polyshift_l_seq: RTL

//  Iterative left shifter, counterpart of the combinational right polyshifter: same four shift types, opposite direction.

---
 rtl/polyshift_l_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/polyshift_l_seq.sv
// Iterative left shifter with four shift types (logic, arithmetic,
// double precision, cyclic). Moves at most STEP bit positions per clock.
// Operand and result sides each use a valid/ready handshake: a transfer
// happens on a rising edge where both valid and ready are high; valid,
// once raised, is held with its data stable until that transfer.
// Only one operation is in flight at a time.
module polyshift_l_seq #(
    parameter int WORD_WIDTH = 8,
    parameter int STEP       = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [WORD_WIDTH-2:0]         c_i,
    input  logic [WORD_WIDTH-1:0]         d_i,
    input  logic [$clog2(WORD_WIDTH)-1:0] shift_size_i,
    input  logic [1:0]                    shift_type_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [WORD_WIDTH-1:0]         d_o,
    output logic                          ovf_o
);

    localparam int SW = $clog2(WORD_WIDTH);
    localparam logic [SW-1:0] STEP_W = SW'(STEP);

    localparam logic [1:0] T_LOGIC  = 2'd0;
    localparam logic [1:0] T_ARITH  = 2'd1;
    localparam logic [1:0] T_DOUBLE = 2'd2;
    localparam logic [1:0] T_CYCLIC = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WORD_WIDTH-1:0]  data_q, data_d;
    logic [WORD_WIDTH-2:0]  fill_q, fill_d;
    logic [SW-1:0]          rem_q, rem_d;
    logic [1:0]             type_q, type_d;
    logic                   ovf_q, ovf_d;

    logic                   accept;
    logic                   ovf_calc;
    logic [SW-1:0]          step_k;
    logic [WORD_WIDTH-1:0]  data_t;
    logic [WORD_WIDTH-2:0]  fill_t;
    logic                   fb_bit;

    assign accept = valid_i && ready_o;

    // State register; reset drops any operation in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: zero shifts skip SHIFT; last SHIFT edge when remaining <= STEP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    state_d = (shift_size_i != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (rem_q <= STEP_W) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_q)
            S_IDLE:  ready_o = 1'b1;
            S_DONE:  valid_o = 1'b1;
            default: begin
                ready_o = 1'b0;
                valid_o = 1'b0;
            end
        endcase
    end

    // Signed overflow: any of the top s+1 bits of the operand differs from its sign.
    always_comb begin
        ovf_calc = 1'b0;
        for (int j = 0; j < WORD_WIDTH; j++) begin
            if ((j >= WORD_WIDTH - 1 - int'(shift_size_i)) && (d_i[j] != d_i[WORD_WIDTH-1])) begin
                ovf_calc = 1'b1;
            end
        end
    end

    // One shift step: up to STEP single-bit moves, fill bit chosen by shift type.
    always_comb begin
        step_k = (rem_q > STEP_W) ? STEP_W : rem_q;
        data_t = data_q;
        fill_t = fill_q;
        fb_bit = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (SW'(i) < rem_q) begin
                case (type_q)
                    T_DOUBLE: fb_bit = fill_t[WORD_WIDTH-2];
                    T_CYCLIC: fb_bit = data_t[WORD_WIDTH-1];
                    default:  fb_bit = 1'b0;
                endcase
                data_t = {data_t[WORD_WIDTH-2:0], fb_bit};
                fill_t = {fill_t[WORD_WIDTH-3:0], 1'b0};
            end
        end
    end

    // Datapath next values: capture on accept, step while shifting, hold otherwise.
    always_comb begin
        data_d = data_q;
        fill_d = fill_q;
        rem_d  = rem_q;
        type_d = type_q;
        ovf_d  = ovf_q;
        if (state_q == S_IDLE && accept) begin
            data_d = d_i;
            fill_d = c_i;
            rem_d  = shift_size_i;
            type_d = shift_type_i;
            ovf_d  = (shift_type_i == T_ARITH) ? ovf_calc : 1'b0;
        end else if (state_q == S_SHIFT) begin
            data_d = data_t;
            fill_d = fill_t;
            rem_d  = rem_q - step_k;
        end
    end

    // Datapath registers; the data register doubles as the held result.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q <= '0;
            fill_q <= '0;
            rem_q  <= '0;
            type_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            fill_q <= fill_d;
            rem_q  <= rem_d;
            type_q <= type_d;
            ovf_q  <= ovf_d;
        end
    end

    assign d_o   = data_q;
    assign ovf_o = ovf_q;

endmodule
